// File: rtl/led_stretch.sv
// Per-channel LED pulse stretcher: each event strobe becomes a fixed-length lit pulse
// followed by a guaranteed dark gap; events arriving mid-blink collapse into one more blink.
module led_stretch #(
  parameter int CHANNELS   = 4,
  parameter int ON_CYCLES  = 5000000,
  parameter int OFF_CYCLES = 5000000,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] evt,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             led_q, busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        pend_q  <= 1'b0;
        led_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pend_q  <= pend_d;
        // Outputs decoded from the next state so they are true flops, aligned with state_q
        led_q   <= (state_d == ON);
        busy_q  <= (state_d != IDLE);
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      unique case (state_q)
        IDLE: begin
          if (evt[i]) begin
            state_d = ON;
            cnt_d   = '0;
            pend_d  = 1'b0;
          end
        end
        ON: begin
          if (evt[i]) pend_d = 1'b1;
          if (cnt_q == ON_LAST) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        GAP: begin
          if (cnt_q == OFF_LAST) begin
            // An event on the final gap cycle starts the next blink directly
            state_d = (pend_q || evt[i]) ? ON : IDLE;
            cnt_d   = '0;
            pend_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (evt[i]) pend_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      endcase
    end

    assign led[i]  = led_q;
    assign busy[i] = busy_q;
  end

endmodule

// File: tb/tb_led_stretch.sv
// Scoreboard bench for led_stretch: a timer-based reference model pushes expected
// led/busy after each edge; the sampler pops and compares 1 time unit later.
module tb_led_stretch;
  localparam int CH   = 2;
  localparam int ONC  = 3;
  localparam int OFFC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] evt = '0;
  logic [CH-1:0] led;
  logic [CH-1:0] busy;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 lit, 2 gap; rem = cycles left in phase
  int phase [CH];
  int rem   [CH];
  bit pend  [CH];

  typedef struct packed {
    logic [CH-1:0] led;
    logic [CH-1:0] busy;
  } exp_t;
  exp_t sb_q[$];

  led_stretch #(
    .CHANNELS  (CH),
    .ON_CYCLES (ONC),
    .OFF_CYCLES(OFFC),
    .CNT_W     (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .evt  (evt),
    .led  (led),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [CH-1:0] got, input logic [CH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      phase[c] = 0;
      rem[c]   = 0;
      pend[c]  = 1'b0;
    end
    sb_q.delete();
  endtask

  task automatic model_step(input logic [CH-1:0] e);
    exp_t x;
    for (int c = 0; c < CH; c++) begin
      if (phase[c] == 0) begin
        if (e[c]) begin
          phase[c] = 1;
          rem[c]   = ONC;
        end
      end else if (phase[c] == 1) begin
        if (e[c]) pend[c] = 1'b1;
        rem[c]--;
        if (rem[c] == 0) begin
          phase[c] = 2;
          rem[c]   = OFFC;
        end
      end else begin
        rem[c]--;
        if (rem[c] == 0) begin
          if (pend[c] || e[c]) begin
            phase[c] = 1;
            rem[c]   = ONC;
          end else begin
            phase[c] = 0;
          end
          pend[c] = 1'b0;
        end else if (e[c]) begin
          pend[c] = 1'b1;
        end
      end
      x.led[c]  = (phase[c] == 1);
      x.busy[c] = (phase[c] != 0);
    end
    sb_q.push_back(x);
  endtask

  // One clock: drive evt on the falling edge, model the rising edge, compare 1 unit later
  task automatic cycle(input string tag, input logic [CH-1:0] e);
    exp_t x;
    @(negedge clk);
    evt = e;
    @(posedge clk);
    model_step(e);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      x = sb_q.pop_front();
      chk({tag, "_led"}, led, x.led);
      chk({tag, "_busy"}, busy, x.busy);
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) cycle(tag, '0);
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_led", led, '0);
    chk("rst_busy", busy, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle
    idle("idle", 10);

    // 2: single pulse on channel 0
    cycle("single", 2'b01);
    idle("single", 8);

    // 3: pulses at +0, +2, +4 merge into exactly two blinks
    cycle("merge", 2'b01);
    cycle("merge", 2'b00);
    cycle("merge", 2'b01);
    cycle("merge", 2'b00);
    cycle("merge", 2'b01);
    idle("merge", 12);

    // 4: channel 1 held high continuously
    for (int k = 0; k < 20; k++) cycle("steady", 2'b10);
    idle("steady", 8);

    // 5: event only on the final gap cycle
    cycle("lastgap", 2'b01);
    idle("lastgap", 4);
    cycle("lastgap", 2'b01);
    chk("lastgap_on", led, 2'b01);
    idle("lastgap", 8);

    // 6: asynchronous reset mid-blink on both channels, with a pending event queued
    cycle("arst", 2'b11);
    cycle("arst", 2'b11);
    chk("arst_pre", led, 2'b11);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_led", led, '0);
    chk("arst_busy", busy, '0);
    @(negedge clk);
    evt   = '0;
    rst_n = 1'b1;
    idle("post_rst", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation bound reached");
    $fatal(1, "timeout");
  end
endmodule
